// File: rtl/cycle_timing_sequencer.sv
// cycle_timing_sequencer
// Synchronous replacement for a multi-tap delay-line timing chain. A cycle
// trigger launches a cycle of SHORT_LEN (or SHORT_LEN+LONG_EXTRA) ticks during
// which five active-low taps pulse at fixed offsets TAP_STEP*(k+1).
//
// Ports:
//   clk          system clock, one tick per rising edge
//   reset        synchronous, active-high reset
//   enable       free-run: chain the next cycle directly after each cycle end
//   start        single-cycle trigger, honoured only when idle
//   ilong        long-cycle request, latched on the edge that enters tick 0
//   halt         stop request, applied at the end of the current cycle
//   tap_n[4:0]   active-low tap pulses, bit k at tick TAP_STEP*(k+1)
//   cycle_start  high during tick 0
//   cycle_end    high during the last tick
//   busy         high from tick 0 through the last tick
//   cur_long     high for the whole of a long cycle
//   cycle_count  completed cycles, wraps modulo 2^16
module cycle_timing_sequencer #(
  parameter int unsigned TAP_STEP   = 2,
  parameter int unsigned PULSE_W    = 1,
  parameter int unsigned SHORT_LEN  = 12,
  parameter int unsigned LONG_EXTRA = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        start,
  input  logic        ilong,
  input  logic        halt,
  output logic [4:0]  tap_n,
  output logic        cycle_start,
  output logic        cycle_end,
  output logic        busy,
  output logic        cur_long,
  output logic [15:0] cycle_count
);

  localparam int unsigned NUM_TAPS = 5;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned LONG_LEN = SHORT_LEN + LONG_EXTRA;
  localparam int unsigned TICK_W   = $clog2(LONG_LEN + 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [TICK_W-1:0]     tick_q, tick_d;
  logic                  long_q, long_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [NUM_TAPS-1:0]   tap_n_q, tap_n_d;
  logic                  start_q, start_d;
  logic                  end_q, end_d;
  logic                  busy_q, busy_d;
  logic                  cur_long_q, cur_long_d;

  logic                  last_tick;
  logic                  run_nx;
  logic [31:0]           tick_nx;
  logic [31:0]           len_nx;
  logic [NUM_TAPS-1:0]   tap_hit;

  // Tick window of each tap, evaluated on the tick the next period will show.
  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
    localparam int unsigned TAP_LO = TAP_STEP * (k + 1);
    assign tap_hit[k] = (tick_nx >= TAP_LO) && (tick_nx < TAP_LO + PULSE_W);
  end

  // Next-state and next-output logic; outputs are derived from the next
  // state so that every output is a plain flop.
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    long_d    = long_q;
    count_d   = count_q;
    last_tick = (state_q == ST_RUN) &&
                (32'(tick_q) == (long_q ? LONG_LEN : SHORT_LEN) - 32'd1);

    case (state_q)
      ST_IDLE: begin
        if ((start | enable) & ~halt) begin
          state_d = ST_RUN;
          tick_d  = '0;
          long_d  = ilong;
        end
      end
      ST_RUN: begin
        if (last_tick) begin
          count_d = count_q + 16'd1;
          if (enable & ~halt) begin
            // back-to-back cycle, no idle gap
            tick_d = '0;
            long_d = ilong;
          end else begin
            state_d = ST_IDLE;
            tick_d  = '0;
            long_d  = 1'b0;
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        tick_d  = '0;
        long_d  = 1'b0;
      end
    endcase

    run_nx     = (state_d == ST_RUN);
    tick_nx    = 32'(tick_d);
    len_nx     = long_d ? LONG_LEN : SHORT_LEN;
    busy_d     = run_nx;
    start_d    = run_nx && (tick_nx == 32'd0);
    end_d      = run_nx && (tick_nx == len_nx - 32'd1);
    cur_long_d = run_nx && long_d;
    tap_n_d    = run_nx ? ~tap_hit : {NUM_TAPS{1'b1}};
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      tick_q     <= '0;
      long_q     <= 1'b0;
      count_q    <= '0;
      tap_n_q    <= {NUM_TAPS{1'b1}};
      start_q    <= 1'b0;
      end_q      <= 1'b0;
      busy_q     <= 1'b0;
      cur_long_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      long_q     <= long_d;
      count_q    <= count_d;
      tap_n_q    <= tap_n_d;
      start_q    <= start_d;
      end_q      <= end_d;
      busy_q     <= busy_d;
      cur_long_q <= cur_long_d;
    end
  end

  assign tap_n       = tap_n_q;
  assign cycle_start = start_q;
  assign cycle_end   = end_q;
  assign busy        = busy_q;
  assign cur_long    = cur_long_q;
  assign cycle_count = count_q;

endmodule

// File: tb/tb_cycle_timing_sequencer.sv
// Bench for cycle_timing_sequencer: a cycle-level reference model (cycle start
// time, length and completed count) is compared against the DUT every clock,
// plus literal expectations at hand-picked ticks.
module tb_cycle_timing_sequencer;

  localparam int TAP_STEP  = 2;
  localparam int PULSE_W   = 1;
  localparam int SHORT_LEN = 12;
  localparam int LONG_LEN  = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        start = 1'b0;
  logic        ilong = 1'b0;
  logic        halt = 1'b0;
  logic [4:0]  tap_n;
  logic        cycle_start;
  logic        cycle_end;
  logic        busy;
  logic        cur_long;
  logic [15:0] cycle_count;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: cycle index of tick 0 of the running cycle.
  int          cyc = 0;
  int          m_t0 = 0;
  bit          m_busy = 1'b0;
  bit          m_long = 1'b0;
  logic [15:0] m_count = 16'd0;
  bit          chk_en = 1'b0;

  always #5 clk = ~clk;

  cycle_timing_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .start       (start),
    .ilong       (ilong),
    .halt        (halt),
    .tap_n       (tap_n),
    .cycle_start (cycle_start),
    .cycle_end   (cycle_end),
    .busy        (busy),
    .cur_long    (cur_long),
    .cycle_count (cycle_count)
  );

  always @(posedge clk) begin
    int len;
    cyc++;
    len = m_long ? LONG_LEN : SHORT_LEN;
    if (reset) begin
      m_busy  = 1'b0;
      m_long  = 1'b0;
      m_count = 16'd0;
    end else if (m_busy) begin
      if ((cyc - 1 - m_t0) == len - 1) begin
        m_count = m_count + 16'd1;
        if (enable && !halt) begin
          m_t0   = cyc;
          m_long = ilong;
        end else begin
          m_busy = 1'b0;
          m_long = 1'b0;
        end
      end
    end else if ((start || enable) && !halt) begin
      m_busy = 1'b1;
      m_t0   = cyc;
      m_long = ilong;
    end
  end

  function automatic logic [4:0] model_tap();
    int t;
    logic [4:0] r;
    t = cyc - m_t0;
    r = 5'b11111;
    for (int k = 0; k < 5; k++)
      if (m_busy && t >= TAP_STEP * (k + 1) && t < TAP_STEP * (k + 1) + PULSE_W)
        r[k] = 1'b0;
    return r;
  endfunction

  function automatic logic [24:0] model_out();
    int t;
    int len;
    t   = cyc - m_t0;
    len = m_long ? LONG_LEN : SHORT_LEN;
    return {model_tap(), 1'(m_busy && t == 0), 1'(m_busy && t == len - 1),
            1'(m_busy), 1'(m_busy && m_long), m_count};
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic [24:0] got;
    logic [24:0] exp;
    if (chk_en) begin
      got = {tap_n, cycle_start, cycle_end, busy, cur_long, cycle_count};
      exp = model_out();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL model_cmp cycle %0d: got tap=%b st=%b end=%b busy=%b long=%b cnt=%h, exp tap=%b st=%b end=%b busy=%b long=%b cnt=%h",
                 cyc, got[24:20], got[19], got[18], got[17], got[16], got[15:0],
                 exp[24:20], exp[19], exp[18], exp[17], exp[16], exp[15:0]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Hand-derived tap pattern for default parameters.
  function automatic logic [4:0] tap_lit(input int t);
    case (t)
      2:       return 5'b11110;
      4:       return 5'b11101;
      6:       return 5'b11011;
      8:       return 5'b10111;
      10:      return 5'b01111;
      default: return 5'b11111;
    endcase
  endfunction

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    step();
    chk_en = 1'b1;
    step();
    reset = 1'b0;

    // idle after reset
    repeat (20) step();
    chk("idle_tap", 16'(tap_n), 16'h001F);
    chk("idle_busy", 16'(busy), 16'd0);
    chk("idle_count", cycle_count, 16'd0);

    // short cycle
    start = 1'b1;
    step();
    start = 1'b0;
    for (int t = 0; t <= 12; t++) begin
      chk("short_tap", 16'(tap_n), 16'(tap_lit(t)));
      chk("model_tap_pin", 16'(model_tap()), 16'(tap_lit(t)));
      if (t == 0)  chk("short_start", 16'(cycle_start), 16'd1);
      if (t == 11) chk("short_end", 16'(cycle_end), 16'd1);
      if (t == 12) begin
        chk("short_busy_after", 16'(busy), 16'd0);
        chk("short_count", cycle_count, 16'd1);
      end
      step();
    end

    // long cycle, ilong dropped at tick 3
    ilong = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int t = 0; t <= 16; t++) begin
      chk("long_cur", 16'(cur_long), 16'(t < 16));
      chk("long_tap", 16'(tap_n), 16'(tap_lit(t)));
      if (t == 15) chk("long_end", 16'(cycle_end), 16'd1);
      if (t == 16) chk("long_count", cycle_count, 16'd2);
      if (t == 3) ilong = 1'b0;
      step();
    end

    // free-run then halt in the 3rd cycle
    pulse_reset();
    enable = 1'b1;
    step();
    chk("run_start1", 16'(cycle_start), 16'd1);
    repeat (12) step();
    chk("run_start2", 16'(cycle_start), 16'd1);
    repeat (18) step();
    chk("run_tick6_tap", 16'(tap_n), 16'h001B);
    halt = 1'b1;
    repeat (5) step();
    chk("halt_end", 16'(cycle_end), 16'd1);
    step();
    chk("halt_busy", 16'(busy), 16'd0);
    chk("halt_count", cycle_count, 16'd3);
    repeat (6) step();
    chk("halt_no_restart", 16'(busy), 16'd0);
    enable = 1'b0;
    halt = 1'b0;
    step();

    // reset mid-cycle during tick 5
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_tap", 16'(tap_n), 16'h001F);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_count", cycle_count, 16'd0);
    repeat (10) step();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (12) step();
    chk("rst_after_count", cycle_count, 16'd1);

    // counter wrap, start ignored while busy
    force dut.count_q = 16'hFFFE;
    m_count = 16'hFFFE;
    step();
    release dut.count_q;
    step();
    chk("wrap_preload", cycle_count, 16'hFFFE);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (12) step();
    chk("wrap_ffff", cycle_count, 16'hFFFF);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (6) step();
    chk("busy_start_end", 16'(cycle_end), 16'd1);
    step();
    chk("wrap_zero", cycle_count, 16'h0000);
    chk("wrap_busy", 16'(busy), 16'd0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
